fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core; it sits directly upstream of `controller`. It owns the PC and issues instruction-memory requests. It presents the ID-stage instruction on `inst_id`, which drives `controller.inst`, and produces the `flush` input consumed by `controller`. It consumes `controller`'s `PC_Src` and the decoded jump-register operand to redirect fetch.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/next_pc_calc.sv | 31 +++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: PC source codes, the nop encoding
// and the fetch FSM state type.
package mips_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JR  = 2'b10;
  localparam logic [1:0] PC_SRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Word offset of a branch immediate, sign-extended to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump-register or jump,
// with redirect targets derived from the IF/ID contents.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst_id,
  input  logic [31:0] pc_plus4_id,
  input  logic [31:0] jr_target,
  input  logic [1:0]  pc_src,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  // The opcode field plays no part in target formation.
  logic unused_opcode;
  assign unused_opcode = ^inst_id[31:26];

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_BR: next_pc = pc_plus4_id + branch_offset(inst_id[15:0]);
      PC_SRC_JR: next_pc = jr_target;
      PC_SRC_J:  next_pc = {pc_plus4_id[31:28], inst_id[25:0], 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, issues imem
// requests, squashes the ID slot on redirects and counts fetches/bubbles.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      jr_target,
  input  logic             stall,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      inst_id,
  output logic [31:0]      pc_plus4_id,
  output logic             valid_id,
  output logic             flush,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e state_reg;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;

  next_pc_calc u_next_pc_calc (
    .pc          (pc),
    .inst_id     (inst_id),
    .pc_plus4_id (pc_plus4_id),
    .jr_target   (jr_target),
    .pc_src      (pc_src),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_ONE;
  endfunction

  assign imem_addr = pc;
  assign imem_req  = (state_reg == RUN) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= BOOT;
      pc          <= RESET_PC;
      inst_id     <= NOP_INST;
      pc_plus4_id <= 32'h0;
      valid_id    <= 1'b0;
      flush       <= 1'b0;
      fetch_cnt   <= '0;
      bubble_cnt  <= '0;
    end else begin
      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          // A stall freezes everything: the ID branch compare is not settled yet.
          if (!stall) begin
            if (pc_src != PC_SRC_SEQ) begin
              pc         <= next_pc;
              inst_id    <= NOP_INST;
              valid_id   <= 1'b0;
              flush      <= 1'b1;
              bubble_cnt <= sat_inc(bubble_cnt);
            end else if (imem_ready) begin
              pc          <= pc_plus4;
              inst_id     <= imem_rdata;
              pc_plus4_id <= pc_plus4;
              valid_id    <= 1'b1;
              flush       <= 1'b0;
              fetch_cnt   <= sat_inc(fetch_cnt);
            end else begin
              inst_id    <= NOP_INST;
              valid_id   <= 1'b0;
              flush      <= 1'b0;
              bubble_cnt <= sat_inc(bubble_cnt);
            end
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random
// traffic, checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int CNT_W = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       pc_src = 2'b00;
  logic [31:0]      jr_target = 32'h0;
  logic             stall = 1'b0;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic [31:0]      imem_rdata = 32'h0;
  logic             imem_ready = 1'b0;
  logic [31:0]      pc;
  logic [31:0]      inst_id;
  logic [31:0]      pc_plus4_id;
  logic             valid_id;
  logic             flush;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_src      (pc_src),
    .jr_target   (jr_target),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .inst_id     (inst_id),
    .pc_plus4_id (pc_plus4_id),
    .valid_id    (valid_id),
    .flush       (flush),
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  typedef struct {
    logic             req;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      pp4;
    logic             valid;
    logic             flush;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] bcnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference model state
  bit               m_boot;
  logic [31:0]      m_pc, m_inst, m_pp4;
  logic             m_valid, m_flush;
  logic [CNT_W-1:0] m_fcnt, m_bcnt;

  task automatic model_reset();
    m_boot = 1'b1; m_pc = RST_PC; m_inst = 32'h0; m_pp4 = 32'h0;
    m_valid = 1'b0; m_flush = 1'b0; m_fcnt = '0; m_bcnt = '0;
  endtask

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1;
  endfunction

  // State after the coming clock edge, from the fetch rules.
  task automatic model_edge(input logic st, input logic [1:0] src, input logic [31:0] jr,
                            input logic rdy, input logic [31:0] rd);
    logic [31:0] target;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!st) begin
      if (src != 2'b00) begin
        case (src)
          2'b01:   target = m_pp4 + 32'($signed(m_inst[15:0])) * 32'd4;
          2'b10:   target = jr;
          default: target = {m_pp4[31:28], 28'(m_inst[25:0] * 4)};
        endcase
        m_pc = target; m_inst = 32'h0; m_valid = 1'b0; m_flush = 1'b1;
        m_bcnt = bump(m_bcnt);
      end else if (rdy) begin
        m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_inst = rd;
        m_valid = 1'b1; m_flush = 1'b0; m_fcnt = bump(m_fcnt);
      end else begin
        m_inst = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_bcnt = bump(m_bcnt);
      end
    end
  endtask

  task automatic push_expect(input logic st);
    exp_t e;
    e.req = !m_boot && !st; e.pc = m_pc; e.inst = m_inst; e.pp4 = m_pp4;
    e.valid = m_valid; e.flush = m_flush; e.fcnt = m_fcnt; e.bcnt = m_bcnt;
    sb.push_back(e);
  endtask

  // One cycle of stimulus: drive after the edge, record expectation, advance model.
  task automatic step(input logic rst_v, input logic st, input logic [1:0] src,
                      input logic [31:0] jr, input logic rdy, input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset = rst_v; stall = st; pc_src = src; jr_target = jr;
    imem_ready = rdy; imem_rdata = rd;
    if (rst_v) model_reset();
    push_expect(rst_v ? 1'b1 : st);
    if (!rst_v) model_edge(st, src, jr, rdy, rd);
    txn++;
  endtask

  // Reset asserted partway through a cycle that is presenting a redirect.
  task automatic step_mid_reset(input logic [1:0] src, input logic [31:0] jr);
    @(posedge clk);
    #1;
    stall = 1'b0; pc_src = src; jr_target = jr; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    #2;
    reset = 1'b1;
    model_reset();
    push_expect(1'b1);
    txn++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("imem_req", 32'(imem_req), 32'(e.req));
      chk("imem_addr", imem_addr, e.pc);
      chk("pc", pc, e.pc);
      chk("inst_id", inst_id, e.inst);
      chk("pc_plus4_id", pc_plus4_id, e.pp4);
      chk("valid_id", 32'(valid_id), 32'(e.valid));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("fetch_cnt", 32'(fetch_cnt), 32'(e.fcnt));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bcnt));
      $display("txn pc=%h inst=%h pp4=%h v=%0d fl=%0d fc=%0d bc=%0d",
               pc, inst_id, pc_plus4_id, valid_id, flush, fetch_cnt, bubble_cnt);
    end
  end

  initial begin
    model_reset();
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 1, 0);
    // Release: BOOT cycle ignores memory, then sequential fetch 0,4,8,...
    step(0, 0, 2'b00, 0, 1, 32'h1111_1111);
    step(0, 0, 2'b00, 0, 1, 32'hAAAA_0001);
    step(0, 0, 2'b00, 0, 1, 32'hBBBB_0002);
    step(0, 0, 2'b00, 0, 1, 32'hCCCC_0003);
    step(0, 0, 2'b00, 0, 1, 32'hDDDD_0004);
    step(0, 0, 2'b00, 0, 1, 32'h1000_0003);   // beq at pc 0x10, pp4 0x14
    step(0, 0, 2'b01, 0, 1, 32'hDEAD_BEEF);   // taken: pc -> 0x20, rdata dropped
    step(0, 0, 2'b00, 0, 1, 32'h0800_0040);   // j 0x40 index fetched at 0x20
    step(0, 0, 2'b11, 0, 1, 32'h0);           // pc -> 0x100
    step(0, 0, 2'b10, 32'h1000_0004, 1, 0);   // jr -> 0x1000_0004
    step(0, 0, 2'b00, 0, 1, 32'h0800_0040);   // j at pp4 0x1000_0008
    step(0, 1, 2'b11, 0, 1, 32'h5555_5555);   // stall hides redirect
    step(0, 1, 2'b11, 0, 1, 32'h6666_6666);
    step(0, 0, 2'b11, 0, 1, 32'h7777_7777);   // pc -> 0x1000_0100
    step(0, 0, 2'b10, 32'h0000_0ABC, 0, 0);   // jr -> 0xABC
    step(0, 0, 2'b10, 32'h0000_0040, 1, 0);   // jr -> 0x40
    step(0, 0, 2'b00, 0, 0, 32'h9999_9999);   // memory wait x3
    step(0, 0, 2'b00, 0, 0, 32'h9999_9999);
    step(0, 0, 2'b00, 0, 0, 32'h9999_9999);
    step(0, 0, 2'b00, 0, 1, 32'h0000_FFFF);   // branch offset -1 word
    step(0, 0, 2'b01, 0, 1, 0);               // pc -> 0x44 + (-4) = 0x40
    step(0, 0, 2'b10, 32'hFFFF_FFFC, 1, 0);   // jr to top of memory
    step(0, 0, 2'b00, 0, 1, 32'h0123_4567);   // wraps to 0
    step(0, 0, 2'b00, 0, 1, 32'h89AB_CDEF);
    step_mid_reset(2'b11, 32'h0);
    step(1, 0, 2'b00, 0, 1, 32'hFFFF_0000);   // in-flight ready ignored
    step(0, 0, 2'b00, 0, 1, 32'h2222_2222);
    step(0, 0, 2'b00, 0, 1, 32'h3333_3333);
    // Random traffic; counters are narrow so saturation is exercised.
    for (int i = 0; i < 400; i++) begin
      logic       st, rdy;
      logic [1:0] src;
      st  = ($urandom_range(0, 4) == 0);
      src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 199) == 0), st, src, $urandom, rdy, $urandom);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
